serializador: RTL

- Byte-to-serial transmitter that sits directly upstream of the deserializer stage and drives its serial data and write-strobe inputs.
- Accepts parallel words through a valid/ready handshake and shifts each word out MSB-first, one bit per clk_100KHz cycle, with write asserted for every bit.
- Waits on the downstream busy flag before starting a word, and inserts a configurable idle gap between words.

---
 rtl/serializador.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/serializador.sv
// serializador: parallel-to-serial transmitter feeding the deserializer stage.
// Each accepted word is shifted out MSB-first with write_out high for every bit.
// The transmitter waits on the downstream busy flag before each word and leaves
// an idle gap after each word.
// Optional build macro SERIALIZADOR_BUF_EN adds a 2-entry input FIFO, so
// ready_out is no longer tied to the IDLE state.
// The serial pins (data_out/write_out) show the SEND state one cycle late.
// As a result, the first bit appears two edges after the accept edge.
module serializador #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk_100KHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             status_in,
  output logic             data_out,
  output logic             write_out,
  output logic             busy_out,
  output logic [7:0]       words_sent
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    SEND    = 2'd2,
    GAP     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             data_q, data_d;
  logic             write_q, write_d;

  logic             accept_c;
  logic             load_c;
  logic             shift_c;
  logic             pending_c;
  logic [WIDTH-1:0] head_c;

  assign accept_c = valid_in & ready_q;

`ifdef SERIALIZADOR_BUF_EN
  logic [WIDTH-1:0] fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]       count_q, count_d;
  logic             push_c, pop_c;

  assign pending_c = (count_q != 2'd0);
  // An empty FIFO lets the incoming word go straight to the shift register
  assign head_c    = pending_c ? fifo0_q : data_in;

  // FIFO bookkeeping: pop when a queued head is loaded, push anything not bypassed
  always_comb begin
    pop_c   = load_c & pending_c;
    push_c  = accept_c & ~(load_c & ~pending_c);
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    count_d = count_q;
    if (pop_c) begin
      fifo0_d = fifo1_q;
      count_d = count_d - 2'd1;
    end
    if (push_c) begin
      if (count_d == 2'd0) begin
        fifo0_d = data_in;
      end else begin
        fifo1_d = data_in;
      end
      count_d = count_d + 2'd1;
    end
  end

  // FIFO storage and occupancy
  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      fifo0_q <= '0;
      fifo1_q <= '0;
      count_q <= 2'd0;
    end else begin
      fifo0_q <= fifo0_d;
      fifo1_q <= fifo1_d;
      count_q <= count_d;
    end
  end
`else
  assign pending_c = 1'b0;
  assign head_c    = data_in;
`endif

  // Next-state decode, bit/gap counters and word counter
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    words_d  = words_q;
    load_c   = 1'b0;
    shift_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_c || accept_c) begin
          load_c  = 1'b1;
          state_d = WAIT_DS;
        end
      end
      WAIT_DS: begin
        if (!status_in) begin
          state_d  = SEND;
          bitcnt_d = '0;
        end
      end
      SEND: begin
        shift_c  = 1'b1;
        bitcnt_d = bitcnt_q + BIT_W'(1);
        if (bitcnt_q == BIT_LAST) begin
          words_d  = words_q + CNT_W'(1);
          bitcnt_d = '0;
          if (GAP_CYCLES != 0) begin
            state_d  = GAP;
            gapcnt_d = '0;
          end else if (pending_c) begin
            // Zero-gap: fold the downstream check into the last bit so words abut
            load_c  = 1'b1;
            state_d = status_in ? WAIT_DS : SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gapcnt_d = gapcnt_q + GAP_W'(1);
        if (gapcnt_q == GAP_LAST) begin
          if (pending_c) begin
            load_c  = 1'b1;
            state_d = WAIT_DS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register: a load takes priority over the per-bit shift
  always_comb begin
    shreg_d = shreg_q;
    if (load_c) begin
      shreg_d = head_c;
    end else if (shift_c) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Registered output decode
  always_comb begin
    write_d = (state_q == SEND);
    data_d  = (state_q == SEND) ? shreg_q[WIDTH-1] : 1'b0;
`ifdef SERIALIZADOR_BUF_EN
    ready_d = (count_d != 2'd2);
    busy_d  = (state_d != IDLE) || (state_q == SEND) || (count_d != 2'd0);
`else
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE) || (state_q == SEND);
`endif
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      words_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      data_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      words_q  <= words_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      write_q  <= write_d;
    end
  end

  assign ready_out  = ready_q;
  assign busy_out   = busy_q;
  assign data_out   = data_q;
  assign write_out  = write_q;
  assign words_sent = words_q;

endmodule
